rf_wport_arbiter: RTL and testbench

//   Shares the single register-file write port between the in-order WB stage and a

---
 rtl/rf_wport_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rf_wport_arbiter                                           |
// | Description : Shares the RF write port between WB and a queue of          |
// |               long-latency results, with starvation-driven WB stalls.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rf_wport_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [37:0] ws_rf_zip,
  input  logic [31:0] ws_pc,
  output logic        ws_stall,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  input  logic [31:0] lu_pc,
  input  logic        flush,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] q_busy_mask,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);
  localparam int c_sw = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [c_cw-1:0] c_depth      = c_cw'(DEPTH);
  localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_MAX);

  logic [4:0]      r_ent_waddr [DEPTH];
  logic [31:0]     r_ent_wdata [DEPTH];
  logic [31:0]     r_ent_pc    [DEPTH];
  logic [c_pw-1:0] r_rd_ptr;
  logic [c_pw-1:0] r_wr_ptr;
  logic [c_cw-1:0] r_count;
  logic [c_sw-1:0] r_starve;

  logic        w_ws_we;
  logic        w_ws_win;
  logic        w_q_grant;
  logic        w_enq;
  logic        w_q_nonempty;
  logic [31:0] w_busy;

  assign w_ws_we      = ws_rf_zip[37];
  assign w_q_nonempty = (r_count != '0);

  // Every output is forced quiet while reset is held, independent of inputs.
  assign ws_stall  = resetn & w_q_nonempty & (r_starve == c_starve_max);
  assign lu_ready  = resetn & (r_count < c_depth) & ~flush;
  assign w_ws_win  = resetn & w_ws_we & ~ws_stall;
  assign w_q_grant = resetn & ~w_ws_win & w_q_nonempty & ~flush;
  assign w_enq     = lu_valid & lu_ready & (lu_waddr != 5'd0);

  always_comb begin
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = 32'd0;
    debug_wb_pc = 32'd0;
    if (w_ws_win) begin
      rf_we       = 1'b1;
      rf_waddr    = ws_rf_zip[36:32];
      rf_wdata    = ws_rf_zip[31:0];
      debug_wb_pc = ws_pc;
    end else if (w_q_grant) begin
      rf_we       = 1'b1;
      rf_waddr    = r_ent_waddr[r_rd_ptr];
      rf_wdata    = r_ent_wdata[r_rd_ptr];
      debug_wb_pc = r_ent_pc[r_rd_ptr];
    end
  end

  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Slot i of the ring is live when its distance from the head is below count.
  always_comb begin
    w_busy = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (c_cw'(i) < r_count)
        w_busy[r_ent_waddr[r_rd_ptr + c_pw'(i)]] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end
  assign q_busy_mask = w_busy;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_enq) begin
        r_ent_waddr[r_wr_ptr] <= lu_waddr;
        r_ent_wdata[r_wr_ptr] <= lu_wdata;
        r_ent_pc[r_wr_ptr]    <= lu_pc;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_q_grant)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + c_cw'(w_enq) - c_cw'(w_q_grant);
      if (w_q_grant || !w_q_nonempty)
        r_starve <= '0;
      else if (r_starve != c_starve_max)
        r_starve <= r_starve + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rf_wport_arbiter                                        |
// | Description : Directed bench for rf_wport_arbiter with a queue model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rf_wport_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [37:0] ws_rf_zip;
  logic [31:0] ws_pc;
  logic        ws_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic [31:0] lu_pc;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] q_busy_mask;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_vec = 0;
  int n_mis = 0;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetn(resetn),
    .ws_rf_zip(ws_rf_zip), .ws_pc(ws_pc), .ws_stall(ws_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr),
    .lu_wdata(lu_wdata), .lu_pc(lu_pc), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_busy_mask(q_busy_mask), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending results in arrival order, plus how long the head has waited.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   m_wait = 0;
  bit   started = 0;

  initial begin
    bit          m_rst, m_pop, m_push, e_stall, e_ready, wb_win, q_win, e_we;
    ent_t        m_new;
    int          sz, nxt_wait;
    logic [4:0]  e_a;
    logic [31:0] e_d, e_pc, e_mask;
    forever begin
      @(negedge clk);
      sz      = mq.size();
      e_stall = resetn && sz != 0 && m_wait == STARVE_MAX;
      e_ready = resetn && sz < DEPTH && !flush;
      wb_win  = resetn && ws_rf_zip[37] && !e_stall;
      q_win   = resetn && !wb_win && sz != 0 && !flush;
      e_we = 1'b0; e_a = 5'd0; e_d = 32'd0; e_pc = 32'd0;
      if (wb_win) begin
        e_we = 1'b1; e_a = ws_rf_zip[36:32]; e_d = ws_rf_zip[31:0]; e_pc = ws_pc;
      end else if (q_win) begin
        e_we = 1'b1; e_a = mq[0].a; e_d = mq[0].d; e_pc = mq[0].pc;
      end
      e_mask = 32'd0;
      foreach (mq[k]) e_mask[mq[k].a] = 1'b1;
      e_mask[0] = 1'b0;
      if (started) begin
        check("rf_we", rf_we, e_we);
        check("rf_waddr", rf_waddr, e_a);
        check("rf_wdata", rf_wdata, e_d);
        check("debug_wb_pc", debug_wb_pc, e_pc);
        check("debug_wb_rf_we", debug_wb_rf_we, {4{e_we}});
        check("debug_wb_rf_wnum", debug_wb_rf_wnum, e_a);
        check("debug_wb_rf_wdata", debug_wb_rf_wdata, e_d);
        check("lu_ready", lu_ready, e_ready);
        check("ws_stall", ws_stall, e_stall);
        check("q_busy_mask", q_busy_mask, e_mask);
      end
      m_rst  = !resetn || flush;
      m_pop  = q_win;
      m_push = lu_valid && e_ready && lu_waddr != 5'd0;
      m_new  = '{a: lu_waddr, d: lu_wdata, pc: lu_pc};
      nxt_wait = (q_win || sz == 0) ? 0 :
                 (m_wait < STARVE_MAX ? m_wait + 1 : STARVE_MAX);
      @(posedge clk);
      if (m_rst) begin
        mq.delete();
        m_wait = 0;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(m_new);
        m_wait = nxt_wait;
      end
      started = 1;
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] wpc, input logic lv, input logic [4:0] la,
                       input logic [31:0] ld, input logic [31:0] lpc, input logic fl);
    ws_rf_zip = {we, wa, wd};
    ws_pc     = wpc;
    lu_valid  = lv;
    lu_waddr  = la;
    lu_wdata  = ld;
    lu_pc     = lpc;
    flush     = fl;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    // WB asserts a write during reset; outputs must still stay quiet.
    drive(1'b1, 5'd9, 32'hDEAD, 32'h40, 1'b1, 5'd4, 32'h1, 32'h44, 1'b0);
    repeat (3) adv();
    @(negedge clk);
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_lu_ready", lu_ready, 1'b0);
    check("reset_mask", q_busy_mask, 32'd0);
    adv();
    resetn = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("release_lu_ready", lu_ready, 1'b1);
    adv();

    // Idle WB, single long-latency write to r5.
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 32'h100, 1'b0);
    @(negedge clk);
    check("t2_rf_we_t0", rf_we, 1'b0);
    adv();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("t2_mask_t1", q_busy_mask, 32'h20);
    check("t2_waddr_t1", {rf_we, rf_waddr}, {1'b1, 5'd5});
    check("t2_wdata_t1", rf_wdata, 32'h1234);
    check("t2_pc_t1", debug_wb_pc, 32'h100);
    adv();
    @(negedge clk);
    check("t2_mask_t2", q_busy_mask, 32'd0);
    check("t2_rf_we_t2", rf_we, 1'b0);
    adv();

    // WB writes every cycle while two results wait; third offer is refused.
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 5'(20 + c), 32'hB000 + c, 32'h300 + 4 * c,
            c < 3, (c == 0) ? 5'd6 : (c == 1) ? 5'd7 : 5'd8,
            32'hA000 + c, 32'h200 + 4 * c, 1'b0);
      @(negedge clk);
      if (c == 2) check("t3_full_not_ready", lu_ready, 1'b0);
      if (c == 4) check("t3_no_stall_yet", ws_stall, 1'b0);
      if (c == 5) begin
        check("t3_stall1", ws_stall, 1'b1);
        check("t3_drain1", {rf_we, rf_waddr, debug_wb_pc}, {1'b1, 5'd6, 32'h200});
      end
      if (c == 6) check("t3_stall_one_cycle", ws_stall, 1'b0);
      if (c == 10) begin
        check("t3_stall2", ws_stall, 1'b1);
        check("t3_drain2", {rf_we, rf_waddr, debug_wb_pc}, {1'b1, 5'd7, 32'h204});
      end
      adv();
    end

    // Flush with r3, r7 queued and a result offered in the flush cycle.
    drive(1'b1, 5'd11, 32'h11, 32'h500, 1'b1, 5'd3, 32'h33, 32'h600, 1'b0);
    adv();
    drive(1'b1, 5'd12, 32'h12, 32'h504, 1'b1, 5'd7, 32'h77, 32'h604, 1'b0);
    adv();
    drive(1'b1, 5'd13, 32'h13, 32'h508, 1'b1, 5'd9, 32'h99, 32'h608, 1'b1);
    @(negedge clk);
    check("t4_mask_before", q_busy_mask, 32'h88);
    check("t4_wb_in_flush", {rf_we, rf_waddr, debug_wb_pc}, {1'b1, 5'd13, 32'h508});
    adv();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("t4_mask_after", q_busy_mask, 32'd0);
    check("t4_no_write", rf_we, 1'b0);
    adv();

    // Result to r0 is handshaken and dropped.
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'h5555, 32'h700, 1'b0);
    @(negedge clk);
    check("t5_ready", lu_ready, 1'b1);
    adv();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("t5_no_write", rf_we, 1'b0);
    check("t5_mask", q_busy_mask, 32'd0);
    adv();

    // Ten back-to-back results with WB idle: each drains one cycle after arrival.
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 5'd0, 32'd0, 32'd0, c < 10, 5'(c + 1), 32'hD000 + c,
            32'h1000 + 4 * c, 1'b0);
      @(negedge clk);
      if (c >= 1 && c <= 10)
        check("t6_order", {rf_we, rf_waddr, debug_wb_pc},
              {1'b1, 5'(c), 32'h1000 + 4 * (c - 1)});
      adv();
    end

    repeat (2) adv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
